// File: rtl/prng_pkg.sv
// Shared constants and FSM encoding for the pseudo-random byte generator.
package prng_pkg;

    // Default feedback masks for a 16-bit data LFSR and an 8-bit control LFSR
    localparam logic [15:0] DATA16_TAPS = 16'hD008;
    localparam logic [7:0]  CTRL8_TAPS  = 8'hB8;

    // Generator run state: OFF holds counters at zero, RUN lets them advance
    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/lfsr_xnor.sv
// Fibonacci XNOR LFSR with seed load. The all-ones pattern is the lockup
// state of an XNOR LFSR, so an all-ones seed is replaced by zero.
module lfsr_xnor #(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = '0
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] seed,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Load has priority over stepping; shift left and feed XNOR of tapped bits into bit 0
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= (&seed) ? '0 : seed;
        end else if (step) begin
            r_q <= {r_q[W-2:0], ~^(r_q & TAPS)};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/prng_lfsr_mux_gen.sv
// Pseudo-random word generator: a 2*OUT_W-bit data LFSR and an OUT_W-bit control
// LFSR feed a bank of 2:1 muxes. Stepping is paced by clock-enable ticks (free-run)
// or by level-sampled requests; the result is offered on a valid/ready output with
// a sticky overrun flag for words dropped while the consumer stalls.
module prng_lfsr_mux_gen
    import prng_pkg::*;
#(
    parameter int                   OUT_W     = 8,
    parameter logic [2*OUT_W-1:0]   DATA_TAPS = DATA16_TAPS,
    parameter logic [OUT_W-1:0]     CTRL_TAPS = CTRL8_TAPS,
    parameter int                   TICK_DIV  = 10_000_000,
    parameter int                   CTRL_DIV  = 4
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 req,
    input  logic                 seed_load,
    input  logic [2*OUT_W-1:0]   data_seed,
    input  logic [OUT_W-1:0]     ctrl_seed,
    output logic [OUT_W-1:0]     rnd_data,
    output logic                 rnd_valid,
    input  logic                 rnd_ready,
    output logic                 overrun,
    output logic                 tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (CTRL_DIV > 1) ? $clog2(CTRL_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CTRL_LAST = CW'(CTRL_DIV - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_active;
    logic [TW-1:0]        r_tick_cnt;
    logic [CW-1:0]        r_ctrl_cnt;
    logic                 w_tick;
    logic                 w_step;
    logic                 w_ctrl_step;
    logic                 r_cap_pend;
    logic [2*OUT_W-1:0]   w_data_q;
    logic [OUT_W-1:0]     w_ctrl_q;
    logic [OUT_W-1:0]     w_word;
    logic [OUT_W-1:0]     r_rnd_data;
    logic                 r_rnd_valid;
    logic                 r_overrun;

    // State register for the OFF/RUN controller
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and step qualification; counting and stepping only while RUN and enabled
    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        case (r_state)
            ST_OFF: if (en)  w_state_nxt = ST_RUN;
            ST_RUN: begin
                w_active = en;
                if (!en) w_state_nxt = ST_OFF;
            end
            default: w_state_nxt = ST_OFF;
        endcase
        w_tick      = w_active && (r_tick_cnt == TICK_LAST);
        w_step      = w_active && !seed_load && (mode ? req : w_tick);
        w_ctrl_step = w_step && (r_ctrl_cnt == CTRL_LAST);
    end

    // Tick divider and control-step divider; both restart from zero when idle or reseeded
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_ctrl_cnt <= '0;
        end else if (seed_load || !w_active) begin
            r_tick_cnt <= '0;
            r_ctrl_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_step) begin
                r_ctrl_cnt <= w_ctrl_step ? '0 : r_ctrl_cnt + 1'b1;
            end
        end
    end

    lfsr_xnor #(
        .W    (2*OUT_W),
        .TAPS (DATA_TAPS)
    ) u_data_lfsr (
        .CLK  (CLK),
        .rst  (rst),
        .step (w_step),
        .load (seed_load),
        .seed (data_seed),
        .q    (w_data_q)
    );

    lfsr_xnor #(
        .W    (OUT_W),
        .TAPS (CTRL_TAPS)
    ) u_ctrl_lfsr (
        .CLK  (CLK),
        .rst  (rst),
        .step (w_ctrl_step),
        .load (seed_load),
        .seed (ctrl_seed),
        .q    (w_ctrl_q)
    );

    // Mux bank: each control bit picks the odd or even bit of its data-bit pair
    always_comb begin
        w_word = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_word[i] = w_ctrl_q[i] ? w_data_q[2*i+1] : w_data_q[2*i];
        end
    end

    // Remember that a step happened so the updated LFSRs are captured next cycle
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_cap_pend <= 1'b0;
        end else begin
            r_cap_pend <= w_step;
        end
    end

    // Output holding register with valid/ready handshake; reseeding discards any pending word
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_rnd_data  <= '0;
            r_rnd_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (seed_load) begin
            r_rnd_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (r_cap_pend) begin
            if (!r_rnd_valid || rnd_ready) begin
                r_rnd_data  <= w_word;
                r_rnd_valid <= 1'b1;
            end else begin
                r_overrun   <= 1'b1;
            end
        end else if (r_rnd_valid && rnd_ready) begin
            r_rnd_valid <= 1'b0;
        end
    end

    assign rnd_data  = r_rnd_data;
    assign rnd_valid = r_rnd_valid;
    assign overrun   = r_overrun;
    assign tick      = w_tick;

endmodule
